scalar_reduce_arbiter: RTL and testbench
========================================

# scalar_reduce_arbiter

Shares one mod-L scalar reducer (512-bit in, 253-bit out, start/done/busy handshake, multi-cycle latency) between two requesters in the Ed25519 signing path: requester 0 (nonce r = H(prefix‖M) mod L) and requester 1 (challenge k = H(R‖A‖M) mod L). It applies round-robin arbitration, latches and holds the selected operand, and sequences the reducer. It returns each result on a single tagged response channel with backpressure, and includes a watchdog that flags a reducer that never completes.

## Interface
- TIMEOUT, 1100: max cycles in WAIT before abort; must exceed reducer latency (1026 cycles for a 512-bit operand).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  request; held with operand until matching gnt pulse.
- din0, din1  in  512  operand; stable while req high.
- gnt0, gnt1  out  1  one-cycle pulse; operand captured this cycle.
- resp_valid  out  1  result available; held until accepted.
- resp_ready  in  1  consumer accepts when valid & ready.
- resp_id  out  1  owner of result (0/1).
- resp_data  out  253  din mod L (0 on error).
- resp_err  out  1  1 = watchdog abort.
- red_start  out  1  one-cycle start pulse to reducer.
- red_din  out  512  latched operand; stable from ISSUE through WAIT.
- red_dout  in  253  reducer result.
- red_done  in  1  reducer completion pulse.
- red_busy  in  1  reducer busy.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if (req0|req1) & !red_busy:
  - pick winner, pulse gnt, latch din into operand register, record owner, go ISSUE.
  - No request or red_busy: stay.
- Arbitration: one request wins outright. On a tie, the winner is the requester not granted last. last_grant resets to 1, so req0 wins the first tie. last_grant updates on every grant.
- ISSUE: red_start=1 for exactly one cycle, clear watchdog counter, go WAIT.
- WAIT: increment watchdog each cycle.
  - red_done: capture red_dout, resp_err=0, go RESP.
  - Counter reaches TIMEOUT-1 without red_done: resp_data=0, resp_err=1, go RESP.
  - If red_done and timeout land in the same cycle, red_done wins.
- RESP: resp_valid=1 with id/data/err stable. On resp_ready, drop valid and go IDLE. Requests arriving meanwhile wait; no grant is given in RESP.
- red_done outside WAIT is ignored.
- red_din holds the latched operand in all states; it changes only on a grant.
- The arbiter never resets the reducer. After rst, IDLE still waits for !red_busy before issuing, so a stale in-flight operation drains first. Its red_done is ignored.
- Widths:
  - Watchdog counter is ceil(log2(TIMEOUT+1)) bits and saturates.
  - resp_data equals red_dout exactly; no further arithmetic.

## Timing
- Reset values: gnt0/1=0, red_start=0, resp_valid=0, resp_id=0, resp_err=0, resp_data=0, red_din=0, last_grant=1, state IDLE, counter 0.
- All outputs are registered.
- Request to grant: the gnt pulse appears the cycle after req is sampled high in IDLE. Requester must hold req/din through that cycle and may drop req the cycle after gnt.
- red_start is asserted the cycle after gnt.
- Result to response: resp_valid rises the cycle after red_done. Acceptance occurs on the valid&ready edge. The next grant is possible one cycle after acceptance, i.e. minimum 2 idle cycles between reducer jobs.
- Total latency is req sample → resp_valid = 3 + reducer latency when uncontested with resp_ready held high.
- Requester must not reassert req until it has accepted its own response; the arbiter does not queue more than one job.

## Test plan
- Single request: req0 with din0 = L+5, resp_ready=1 → one gnt0 pulse, one red_start, later resp_valid with id=0, data=5, err=0. Grant and response cycles match the Timing section.
- Zero and max operand: din1=0 → data=0. din1=2^512−1 → data equals the golden model mod L, id=1.
- Tie: req0 and req1 raised in the same cycle from reset → gnt0 first. After its response, gnt1 without req0 being dropped. A third tie → gnt0. Alternation holds over 6 jobs.
- Backpressure: resp_ready=0 for 50 cycles after valid → valid, id and data hold stable. No gnt and no red_start occur while pending req1 waits.
- Watchdog: stub reducer that never asserts red_done, TIMEOUT=20 → resp_valid exactly 20 cycles after ISSUE, err=1, data=0. The next request is served normally.
- Reset mid-WAIT: rst for 1 cycle while the stub keeps red_busy=1 for 30 more cycles → outputs at reset values. With req0 held, no gnt until red_busy falls. Stale red_done produces no response.

Source files
------------

// File: rtl/scalar_reduce_arbiter_if.sv
// Bundle of requester, response and reducer signals for the arbiter.
// master = arbiter side, slave = requesters, consumer and reducer.
interface scalar_reduce_arbiter_if;
  logic         req0;
  logic         req1;
  logic [511:0] din0;
  logic [511:0] din1;
  logic         gnt0;
  logic         gnt1;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_id;
  logic [252:0] resp_data;
  logic         resp_err;
  logic         red_start;
  logic [511:0] red_din;
  logic [252:0] red_dout;
  logic         red_done;
  logic         red_busy;

  modport master (
    input  req0, req1, din0, din1,
    input  resp_ready,
    input  red_dout, red_done, red_busy,
    output gnt0, gnt1,
    output resp_valid, resp_id, resp_data, resp_err,
    output red_start, red_din
  );

  modport slave (
    output req0, req1, din0, din1,
    output resp_ready,
    output red_dout, red_done, red_busy,
    input  gnt0, gnt1,
    input  resp_valid, resp_id, resp_data, resp_err,
    input  red_start, red_din
  );
endinterface

// File: rtl/scalar_reduce_arbiter.sv
// Round-robin share of one mod-L scalar reducer between two requesters,
// with a tagged backpressured response channel and a completion watchdog.
module scalar_reduce_arbiter #(
  parameter int TIMEOUT = 1100
) (
  input logic                    clk,
  input logic                    rst,
  scalar_reduce_arbiter_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic          last;
  logic          last_d;
  logic          gnt0_q;
  logic          gnt0_d;
  logic          gnt1_q;
  logic          gnt1_d;
  logic          start_q;
  logic          start_d;
  logic          valid_q;
  logic          valid_d;
  logic          id_q;
  logic          id_d;
  logic          err_q;
  logic          err_d;
  logic [252:0]  data_q;
  logic [252:0]  data_d;
  logic [511:0]  din_q;
  logic [511:0]  din_d;
  logic          win1;

  // Requester 1 wins alone, or on a tie when 0 was granted last.
  assign win1 = bus.req1 & (~bus.req0 | ~last);

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.red_start  = start_q;
  assign bus.red_din    = din_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_err   = err_q;
  assign bus.resp_data  = data_q;

  // Next-state and next-output logic; all outputs come from registers.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    last_d  = last;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    start_d = 1'b0;
    valid_d = valid_q;
    id_d    = id_q;
    err_d   = err_q;
    data_d  = data_q;
    din_d   = din_q;
    unique case (state)
      IDLE: begin
        if ((bus.req0 | bus.req1) & ~bus.red_busy) begin
          gnt0_d  = ~win1;
          gnt1_d  = win1;
          last_d  = win1;
          id_d    = win1;
          din_d   = win1 ? bus.din1 : bus.din0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.red_done) begin
          data_d  = bus.red_dout;
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = RESP;
        end else if (cnt >= TO_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      din_q   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      last    <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      start_q <= start_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      err_q   <= err_d;
      data_q  <= data_d;
      din_q   <= din_d;
    end
  end
endmodule

// File: tb/tb_scalar_reduce_arbiter.sv
// Bench for scalar_reduce_arbiter: stub reducer, vector table,
// hand-written corner sequences and randomized jobs.
module tb_scalar_reduce_arbiter;
  localparam int TO = 20;
  localparam logic [511:0] L =
    512'h10000000000000000000000000000000_14def9dea2f79cd65812631a5cf5d3ed;

  logic clk = 1'b0;
  logic rst = 1'b1;

  scalar_reduce_arbiter_if ifc ();

  scalar_reduce_arbiter #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit mlast = 1'b1;

  function automatic logic [252:0] gold(input logic [511:0] x);
    logic [511:0] t;
    t = x % L;
    return t[252:0];
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Stub reducer: fixed latency per job, optional hang, never reset.
  bit           hang = 1'b0;
  int           lat  = 5;
  int           s_cnt = 0;
  logic [511:0] s_din = '0;
  logic         sb_busy = 1'b0;
  logic         sb_done = 1'b0;
  logic [252:0] sb_dout = '0;

  assign ifc.red_busy = sb_busy;
  assign ifc.red_done = sb_done;
  assign ifc.red_dout = sb_dout;

  always @(posedge clk) begin
    sb_done <= 1'b0;
    if (ifc.red_start && !hang && !sb_busy) begin
      s_din   <= ifc.red_din;
      s_cnt   <= lat;
      sb_busy <= 1'b1;
    end else if (sb_busy) begin
      if (s_cnt <= 1) begin
        sb_done <= 1'b1;
        sb_dout <= gold(s_din);
        sb_busy <= 1'b0;
      end else begin
        s_cnt <= s_cnt - 1;
      end
    end
  end

  // Event recorder sampled just after each rising edge.
  int cyc = 0;
  int gnt_cyc = -1;
  int start_cyc = -1;
  int done_cyc = -1;
  int valid_cyc = -1;
  int vrise = 0;
  bit pv = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (ifc.gnt0 || ifc.gnt1) gnt_cyc = cyc;
    if (ifc.red_start) start_cyc = cyc;
    if (ifc.red_done) done_cyc = cyc;
    if (ifc.resp_valid && !pv) begin
      valid_cyc = cyc;
      vrise     = vrise + 1;
    end
    pv = ifc.resp_valid;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_gnt(output bit id);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ifc.gnt0 || ifc.gnt1) && n < 300);
    if (!(ifc.gnt0 || ifc.gnt1)) begin
      total++;
      bad++;
      $display("FAIL gnt_wait: got none want grant in %0d", n);
    end
    id = ifc.gnt1;
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifc.resp_valid && n < 300);
    if (!ifc.resp_valid) begin
      total++;
      bad++;
      $display("FAIL valid_wait: got none want resp_valid in %0d", n);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt_start"},
        {ifc.gnt0, ifc.gnt1, ifc.red_start}, 3'b000);
    chk({tag, "_resp_flags"},
        {ifc.resp_valid, ifc.resp_id, ifc.resp_err}, 3'b000);
    chk({tag, "_resp_data"}, ifc.resp_data, 253'd0);
    chk({tag, "_red_din"}, ifc.red_din, 512'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mlast = 1'b1;
  endtask

  // One round: raise the chosen requests, serve one job per requester.
  task automatic serve(input bit r0, input bit r1,
                       input logic [511:0] d0, input logic [511:0] d1,
                       input logic [252:0] e0, input logic [252:0] e1,
                       input bit first, input int stall);
    int  rc;
    int  acc;
    int  njobs;
    bit  gid;
    bit  want;
    ifc.din0 = d0;
    ifc.din1 = d1;
    ifc.req0 = r0;
    ifc.req1 = r1;
    rc = cyc;
    acc = 0;
    njobs = (r0 && r1) ? 2 : 1;
    for (int j = 0; j < njobs; j++) begin
      if (j == 0) want = (r0 && r1) ? first : r1;
      else want = !first;
      wait_gnt(gid);
      chk("gnt_id", gid, want);
      if (j == 0) chk("gnt_lat", gnt_cyc, rc + 1);
      else chk("gnt_gap", gnt_cyc, acc + 2);
      if (gid) ifc.req1 = 1'b0;
      else ifc.req0 = 1'b0;
      wait_valid();
      chk("start_lat", start_cyc, gnt_cyc + 1);
      chk("valid_lat", valid_cyc, done_cyc + 1);
      repeat (stall) @(negedge clk);
      ifc.resp_ready = 1'b1;
      chk("resp_id", ifc.resp_id, want);
      chk("resp_data", ifc.resp_data, want ? e1 : e0);
      chk("resp_err", ifc.resp_err, 1'b0);
      acc = cyc;
      @(negedge clk);
      ifc.resp_ready = 1'b0;
      chk("valid_drop", ifc.resp_valid, 1'b0);
      mlast = want;
    end
  endtask

  // Job whose reducer is late or absent; expects the watchdog abort.
  task automatic serve_to(input bit r, input logic [511:0] d);
    bit gid;
    int v;
    if (r) begin
      ifc.din1 = d;
      ifc.req1 = 1'b1;
    end else begin
      ifc.din0 = d;
      ifc.req0 = 1'b1;
    end
    wait_gnt(gid);
    chk("to_gnt_id", gid, r);
    ifc.req0 = 1'b0;
    ifc.req1 = 1'b0;
    wait_valid();
    chk("to_delay", valid_cyc - start_cyc, TO);
    chk("to_err", ifc.resp_err, 1'b1);
    chk("to_data", ifc.resp_data, 253'd0);
    chk("to_id", ifc.resp_id, r);
    ifc.resp_ready = 1'b1;
    @(negedge clk);
    ifc.resp_ready = 1'b0;
    mlast = r;
    v = vrise;
    repeat (25) @(negedge clk);
    chk("to_quiet", vrise, v);
  endtask

  typedef struct {
    bit           r0;
    bit           r1;
    logic [511:0] d0;
    logic [511:0] d1;
    bit           first;
    logic [252:0] e0;
    logic [252:0] e1;
  } vec_t;

  vec_t tbl [6];

  initial begin
    bit           gid;
    bit           ok;
    int           acc;
    int           rc;
    int           v;
    logic [511:0] ones;
    logic [511:0] d;
    logic [511:0] d2;
    logic [1:0]   rr;

    ones = '1;
    tbl[0] = '{1'b1, 1'b0, L + 5, 512'd0, 1'b0, 253'd5, 253'd0};
    tbl[1] = '{1'b0, 1'b1, 512'd0, 512'd0, 1'b0, 253'd0, 253'd0};
    tbl[2] = '{1'b0, 1'b1, 512'd0, ones, 1'b0, 253'd0, gold(ones)};
    tbl[3] = '{1'b1, 1'b1, L, 2 * L + 7, 1'b0, 253'd0, 253'd7};
    tbl[4] = '{1'b1, 1'b1, 512'd3, L - 1, 1'b0, 253'd3,
               253'(L - 1)};
    tbl[5] = '{1'b1, 1'b0, L - 1, 512'd0, 1'b0, 253'(L - 1), 253'd0};

    ifc.req0 = 1'b0;
    ifc.req1 = 1'b0;
    ifc.din0 = '0;
    ifc.din1 = '0;
    ifc.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;
    @(negedge clk);

    // Both requests held from reset: grants alternate starting with 0.
    ifc.din0 = L + 11;
    ifc.din1 = 512'd42;
    ifc.req0 = 1'b1;
    ifc.req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      lat = 4 + k;
      wait_gnt(gid);
      chk("alt_id", gid, k[0]);
      if (k == 5) begin
        ifc.req0 = 1'b0;
        ifc.req1 = 1'b0;
      end
      wait_valid();
      ifc.resp_ready = 1'b1;
      chk("alt_data", ifc.resp_data, k[0] ? 253'd42 : 253'd11);
      chk("alt_rid", ifc.resp_id, k[0]);
      @(negedge clk);
      ifc.resp_ready = 1'b0;
    end
    repeat (3) @(negedge clk);

    do_reset();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      lat = $urandom_range(2, 15);
      serve(tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1,
            tbl[i].e0, tbl[i].e1, tbl[i].first, i % 3);
    end

    // Backpressure: response held 50 cycles while req1 waits.
    lat = 7;
    d = rnd512();
    ifc.din0 = d;
    ifc.req0 = 1'b1;
    wait_gnt(gid);
    chk("bp_gnt0", gid, 1'b0);
    ifc.req0 = 1'b0;
    ifc.din1 = 512'd99;
    ifc.req1 = 1'b1;
    wait_valid();
    ok = 1'b1;
    v = start_cyc;
    for (int i = 0; i < 50; i++) begin
      if (!ifc.resp_valid || ifc.resp_id != 1'b0 ||
          ifc.resp_data != gold(d) || ifc.gnt0 || ifc.gnt1 ||
          ifc.red_start)
        ok = 1'b0;
      @(negedge clk);
    end
    chk("bp_hold", ok, 1'b1);
    chk("bp_no_start", start_cyc, v);
    ifc.resp_ready = 1'b1;
    chk("bp_data", ifc.resp_data, gold(d));
    acc = cyc;
    @(negedge clk);
    ifc.resp_ready = 1'b0;
    wait_gnt(gid);
    chk("bp_gnt1", gid, 1'b1);
    chk("bp_gnt_gap", gnt_cyc, acc + 2);
    ifc.req1 = 1'b0;
    wait_valid();
    ifc.resp_ready = 1'b1;
    chk("bp_data1", ifc.resp_data, 253'd99);
    @(negedge clk);
    ifc.resp_ready = 1'b0;
    mlast = 1'b1;

    // Watchdog: hung reducer, then done exactly at / just past timeout.
    hang = 1'b1;
    serve_to(1'b1, rnd512());
    hang = 1'b0;
    lat = 6;
    d = rnd512();
    serve(1'b0, 1'b1, 512'd0, d, 253'd0, gold(d), 1'b0, 0);
    lat = TO - 2;
    d = rnd512();
    serve(1'b1, 1'b0, d, 512'd0, gold(d), 253'd0, 1'b0, 1);
    lat = TO - 1;
    serve_to(1'b0, rnd512());

    // Randomized rounds against the arbitration/mod-L model.
    for (int i = 0; i < 30; i++) begin
      rr = 2'($urandom_range(1, 3));
      d  = rnd512();
      d2 = ($urandom_range(0, 3) == 0) ? 512'($urandom) : rnd512();
      lat = $urandom_range(1, 15);
      serve(rr[0], rr[1], d, d2, gold(d), gold(d2), !mlast,
            $urandom_range(0, 3));
    end

    // Reset mid-WAIT: stale job drains, its done is ignored.
    lat = 40;
    d = rnd512();
    ifc.din0 = d;
    ifc.req0 = 1'b1;
    wait_gnt(gid);
    ifc.req0 = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst1");
    chk("rst1_busy", ifc.red_busy, 1'b1);
    rst = 1'b0;
    rc = cyc;
    v = vrise;
    d2 = rnd512();
    ifc.din0 = d2;
    ifc.req0 = 1'b1;
    lat = 5;
    wait_gnt(gid);
    chk("rst_gnt_id", gid, 1'b0);
    chk("rst_stale_done", done_cyc > rc, 1'b1);
    chk("rst_gnt_wait", gnt_cyc, done_cyc + 1);
    chk("rst_stale_quiet", vrise, v);
    ifc.req0 = 1'b0;
    wait_valid();
    ifc.resp_ready = 1'b1;
    chk("rst_data", ifc.resp_data, gold(d2));
    chk("rst_err", ifc.resp_err, 1'b0);
    chk("rst_one_resp", vrise, v + 1);
    @(negedge clk);
    ifc.resp_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
